// File: rtl/axi4_wr_outstanding_limiter.sv
// AXI4 write-path gate: caps outstanding AW transactions, holds W until its AW has been accepted,
// and quiesces the port on drain_req. Define AXI4_WR_LIMIT_STATS_EN to add the aw_stall_cycles counter.
module axi4_wr_outstanding_limiter #(
   parameter int  MAX_OUTSTANDING = 8,
   localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic             s_awvalid,
   output logic             s_awready,
   output logic             m_awvalid,
   input  logic             m_awready,
   input  logic             s_wvalid,
   input  logic             s_wlast,
   output logic             s_wready,
   output logic             m_wvalid,
   input  logic             m_wready,
   input  logic             bvalid,
   input  logic             bready,
   input  logic             drain_req,
   output logic             drain_done,
   output logic [CNT_W-1:0] wr_outstanding,
   output logic             err_underflow
`ifdef AXI4_WR_LIMIT_STATS_EN
   ,
   output logic [31:0]      aw_stall_cycles
`endif
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic [CNT_W-1:0] aw_credit_q, aw_credit_d;
   logic             err_q, err_d;
   logic             aw_allow, w_allow;
   logic             aw_hs, w_last_hs, b_hs;

   // Gating depends only on registered state, so no ready/valid combinational loop forms.
   assign w_allow   = (aw_credit_q != '0);
   assign m_awvalid = s_awvalid & aw_allow;
   assign s_awready = m_awready & aw_allow;
   assign m_wvalid  = s_wvalid & w_allow;
   assign s_wready  = m_wready & w_allow;

   assign aw_hs     = m_awvalid & m_awready;
   assign w_last_hs = m_wvalid & m_wready & s_wlast;
   assign b_hs      = bvalid & bready;

   always_comb begin
      out_cnt_d = out_cnt_q;
      err_d     = err_q;
      case ({aw_hs, b_hs})
         2'b10: out_cnt_d = out_cnt_q + ONE_C;
         2'b01: begin
            if (out_cnt_q == '0) err_d = 1'b1;
            else                 out_cnt_d = out_cnt_q - ONE_C;
         end
         default: out_cnt_d = out_cnt_q;
      endcase
   end

   always_comb begin
      aw_credit_d = aw_credit_q;
      if (aw_hs && !w_last_hs)      aw_credit_d = aw_credit_q + ONE_C;
      else if (!aw_hs && w_last_hs) aw_credit_d = aw_credit_q - ONE_C;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= RUN;
         out_cnt_q   <= '0;
         aw_credit_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_cnt_q   <= out_cnt_d;
         aw_credit_q <= aw_credit_d;
         err_q       <= err_d;
      end
   end

   // Emptiness is judged on this edge's post-update counts; a dropped request wins over a tie.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (drain_req) state_d = DRAIN;
         DRAIN: begin
            if (!drain_req)                                   state_d = RUN;
            else if (out_cnt_d == '0 && aw_credit_d == '0)    state_d = DRAINED;
         end
         DRAINED: if (!drain_req) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      aw_allow   = (state_q == RUN) && (out_cnt_q < MAX_C);
      drain_done = (state_q == DRAINED);
   end

   assign wr_outstanding = out_cnt_q;
   assign err_underflow  = err_q;

`ifdef AXI4_WR_LIMIT_STATS_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (s_awvalid && !aw_allow && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge aclk) begin
      if (areset) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign aw_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_axi4_wr_outstanding_limiter.sv
// Directed bench for axi4_wr_outstanding_limiter: limit, W gating, underflow, drain, reset.
module tb_axi4_wr_outstanding_limiter;

   localparam int CNT_W = 4;

   logic             aclk = 1'b0;
   logic             areset;
   logic             s_awvalid, s_awready, m_awvalid, m_awready;
   logic             s_wvalid, s_wlast, s_wready, m_wvalid, m_wready;
   logic             bvalid, bready, drain_req, drain_done, err_underflow;
   logic [CNT_W-1:0] wr_outstanding;
`ifdef AXI4_WR_LIMIT_STATS_EN
   logic [31:0]      aw_stall_cycles;
`endif

   int vectors    = 0;
   int miscompares = 0;

   always #5 aclk = ~aclk;

   axi4_wr_outstanding_limiter #(.MAX_OUTSTANDING(8)) dut (
      .aclk(aclk), .areset(areset),
      .s_awvalid(s_awvalid), .s_awready(s_awready),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .bvalid(bvalid), .bready(bready),
      .drain_req(drain_req), .drain_done(drain_done),
      .wr_outstanding(wr_outstanding), .err_underflow(err_underflow)
`ifdef AXI4_WR_LIMIT_STATS_EN
      , .aw_stall_cycles(aw_stall_cycles)
`endif
   );

   // Advance one edge, then settle away from it.
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic idle_inputs();
      s_awvalid = 0; m_awready = 0; s_wvalid = 0; s_wlast = 0; m_wready = 0;
      bvalid = 0; bready = 0; drain_req = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      areset = 1;
      tick(); tick();
      areset = 0;
      #1;
   endtask

   task automatic issue_aw(input int n);
      s_awvalid = 1; m_awready = 1;
      repeat (n) tick();
      s_awvalid = 0; m_awready = 0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      s_wvalid = 1; m_wready = 1; #1;
      vectors++; if (wr_outstanding !== 4'd0) begin miscompares++; $display("FAIL reset_outstanding got %0d want 0", wr_outstanding); end
      vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL reset_err got %0b want 0", err_underflow); end
      vectors++; if (drain_done !== 1'b0) begin miscompares++; $display("FAIL reset_drain_done got %0b want 0", drain_done); end
      vectors++; if (s_wready !== 1'b0) begin miscompares++; $display("FAIL reset_wready got %0b want 0", s_wready); end
      s_wvalid = 0; m_wready = 0;
   endtask

   task automatic test_limit();
      do_reset();
      s_awvalid = 1; m_awready = 1;
      for (int i = 0; i < 8; i++) begin
         #1;
         vectors++; if (s_awready !== 1'b1) begin miscompares++; $display("FAIL limit_accept%0d got %0b want 1", i, s_awready); end
         tick();
      end
      vectors++; if (wr_outstanding !== 4'd8) begin miscompares++; $display("FAIL limit_count got %0d want 8", wr_outstanding); end
      vectors++; if (s_awready !== 1'b0) begin miscompares++; $display("FAIL limit_9th_ready got %0b want 0", s_awready); end
      vectors++; if (m_awvalid !== 1'b0) begin miscompares++; $display("FAIL limit_9th_valid got %0b want 0", m_awvalid); end
      bvalid = 1; bready = 1;
      tick();
      bvalid = 0; bready = 0; #1;
      vectors++; if (wr_outstanding !== 4'd7) begin miscompares++; $display("FAIL limit_after_b got %0d want 7", wr_outstanding); end
      vectors++; if (s_awready !== 1'b1 || m_awvalid !== 1'b1) begin miscompares++; $display("FAIL limit_9th_accept got %0b%0b want 11", s_awready, m_awvalid); end
      tick();
      s_awvalid = 0; m_awready = 0; #1;
      vectors++; if (wr_outstanding !== 4'd8) begin miscompares++; $display("FAIL limit_refill got %0d want 8", wr_outstanding); end
   endtask

   task automatic test_w_gate();
      do_reset();
      s_wvalid = 1; m_wready = 1; s_wlast = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++; if (m_wvalid !== 1'b0) begin miscompares++; $display("FAIL wgate_noaw%0d got %0b want 0", i, m_wvalid); end
         tick();
      end
      s_awvalid = 1; m_awready = 1; #1;
      vectors++; if (m_wvalid !== 1'b0) begin miscompares++; $display("FAIL wgate_same_cycle got %0b want 0", m_wvalid); end
      tick();
      s_awvalid = 0; m_awready = 0;
      for (int b = 1; b <= 4; b++) begin
         s_wlast = (b == 4); #1;
         vectors++; if (m_wvalid !== 1'b1 || s_wready !== 1'b1) begin miscompares++; $display("FAIL wgate_beat%0d got %0b%0b want 11", b, m_wvalid, s_wready); end
         tick();
      end
      s_wlast = 0; #1;
      vectors++; if (m_wvalid !== 1'b0 || s_wready !== 1'b0) begin miscompares++; $display("FAIL wgate_closed got %0b%0b want 00", m_wvalid, s_wready); end
      vectors++; if (wr_outstanding !== 4'd1) begin miscompares++; $display("FAIL wgate_outstanding got %0d want 1", wr_outstanding); end
      s_wvalid = 0; m_wready = 0;
   endtask

   task automatic test_simultaneous();
      do_reset();
      issue_aw(3);
      vectors++; if (wr_outstanding !== 4'd3) begin miscompares++; $display("FAIL simul_pre got %0d want 3", wr_outstanding); end
      s_awvalid = 1; m_awready = 1; bvalid = 1; bready = 1;
      tick();
      idle_inputs(); #1;
      vectors++; if (wr_outstanding !== 4'd3) begin miscompares++; $display("FAIL simul_post got %0d want 3", wr_outstanding); end
   endtask

   task automatic test_underflow();
      do_reset();
      bvalid = 1; bready = 1;
      tick();
      bvalid = 0; bready = 0; #1;
      vectors++; if (err_underflow !== 1'b1) begin miscompares++; $display("FAIL uflow_set got %0b want 1", err_underflow); end
      vectors++; if (wr_outstanding !== 4'd0) begin miscompares++; $display("FAIL uflow_count got %0d want 0", wr_outstanding); end
      issue_aw(1);
      tick(); tick();
      vectors++; if (err_underflow !== 1'b1) begin miscompares++; $display("FAIL uflow_sticky got %0b want 1", err_underflow); end
      do_reset();
      vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL uflow_clear got %0b want 0", err_underflow); end
   endtask

   task automatic test_drain();
      do_reset();
      issue_aw(2);
      drain_req = 1;
      tick();
      s_awvalid = 1; m_awready = 1; #1;
      vectors++; if (m_awvalid !== 1'b0 || s_awready !== 1'b0) begin miscompares++; $display("FAIL drain_aw_block got %0b%0b want 00", m_awvalid, s_awready); end
      vectors++; if (drain_done !== 1'b0) begin miscompares++; $display("FAIL drain_early got %0b want 0", drain_done); end
      s_awvalid = 0; m_awready = 0;
      s_wvalid = 1; s_wlast = 1; m_wready = 1;
      tick(); tick();
      s_wvalid = 0; s_wlast = 0; m_wready = 0; #1;
      vectors++; if (drain_done !== 1'b0 || wr_outstanding !== 4'd2) begin miscompares++; $display("FAIL drain_after_w got done=%0b cnt=%0d want done=0 cnt=2", drain_done, wr_outstanding); end
      bvalid = 1; bready = 1;
      tick();
      #1;
      vectors++; if (drain_done !== 1'b0) begin miscompares++; $display("FAIL drain_one_b got %0b want 0", drain_done); end
      tick();
      bvalid = 0; bready = 0; #1;
      vectors++; if (drain_done !== 1'b1 || wr_outstanding !== 4'd0) begin miscompares++; $display("FAIL drain_done got done=%0b cnt=%0d want done=1 cnt=0", drain_done, wr_outstanding); end
      drain_req = 0;
      tick();
      s_awvalid = 1; #1;
      vectors++; if (drain_done !== 1'b0 || m_awvalid !== 1'b1) begin miscompares++; $display("FAIL drain_release got done=%0b awv=%0b want done=0 awv=1", drain_done, m_awvalid); end
      s_awvalid = 0;
      // Already-empty port: two edges to drain_done.
      do_reset();
      drain_req = 1;
      tick();
      vectors++; if (drain_done !== 1'b0) begin miscompares++; $display("FAIL drain_empty_edge1 got %0b want 0", drain_done); end
      tick();
      vectors++; if (drain_done !== 1'b1) begin miscompares++; $display("FAIL drain_empty_edge2 got %0b want 1", drain_done); end
      drain_req = 0;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      issue_aw(5);
      s_wvalid = 1; s_wlast = 1; m_wready = 1;
      repeat (3) tick();
      s_wlast = 0; #1;
      vectors++; if (wr_outstanding !== 4'd5 || s_wready !== 1'b1) begin miscompares++; $display("FAIL mid_pre got cnt=%0d wr=%0b want cnt=5 wr=1", wr_outstanding, s_wready); end
      areset = 1;
      tick();
      areset = 0; #1;
      vectors++; if (wr_outstanding !== 4'd0 || s_wready !== 1'b0 || m_wvalid !== 1'b0) begin miscompares++; $display("FAIL mid_reset got cnt=%0d wr=%0b wv=%0b want 0 0 0", wr_outstanding, s_wready, m_wvalid); end
      s_awvalid = 1; m_awready = 1; #1;
      vectors++; if (s_awready !== 1'b1 || drain_done !== 1'b0) begin miscompares++; $display("FAIL mid_run got rdy=%0b done=%0b want 1 0", s_awready, drain_done); end
      idle_inputs();
   endtask

`ifdef AXI4_WR_LIMIT_STATS_EN
   task automatic test_stats();
      do_reset();
      vectors++; if (aw_stall_cycles !== 32'd0) begin miscompares++; $display("FAIL stats_reset got %0d want 0", aw_stall_cycles); end
      drain_req = 1;
      tick();
      s_awvalid = 1; m_awready = 1;
      repeat (10) tick();
      s_awvalid = 0; m_awready = 0; #1;
      vectors++; if (aw_stall_cycles !== 32'd10) begin miscompares++; $display("FAIL stats_count got %0d want 10", aw_stall_cycles); end
      drain_req = 0;
   endtask
`endif

   initial begin
      areset = 1;
      idle_inputs();
      test_reset();
      test_limit();
      test_w_gate();
      test_simultaneous();
      test_underflow();
      test_drain();
      test_reset_mid_burst();
`ifdef AXI4_WR_LIMIT_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axi4_wr_outstanding_limiter.md
Name: axi4_wr_outstanding_limiter

Overview:
- Per-master-port write-path gate, placed directly upstream of one master port of the 17x17 interconnect, between the VIP/master and the interconnect slave-side port.
- Caps accepted-but-unresponded write transactions at MAX_OUTSTANDING.
- Forbids W beats from leading their AW.
- Provides a drain handshake that quiesces the port's write traffic before reconfiguration.
- Gates only valid/ready; AW/W payload wires (addr, id, data, strb, user) bypass the block.

Parameters:
- MAX_OUTSTANDING, 8, maximum AW handshakes without a matching B handshake; legal range 1..255.
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding and credit counters; derived, never overridden.

Ports:
- aclk  input  1  clock; all state updates on rising edge.
- areset  input  1  synchronous, active-high reset.
- s_awvalid  input  1  AW valid from master.
- s_awready  output  1  AW ready to master.
- m_awvalid  output  1  AW valid to interconnect.
- m_awready  input  1  AW ready from interconnect.
- s_wvalid  input  1  W valid from master.
- s_wlast  input  1  W last from master.
- s_wready  output  1  W ready to master.
- m_wvalid  output  1  W valid to interconnect.
- m_wready  input  1  W ready from interconnect.
- bvalid  input  1  B valid, observed on the master/interconnect B channel.
- bready  input  1  B ready, observed.
- drain_req  input  1  level request to quiesce writes.
- drain_done  output  1  port quiesced.
- wr_outstanding  output  CNT_W  current outstanding count.
- err_underflow  output  1  sticky; set by a B handshake while wr_outstanding==0.

Behaviour:
- Internal state:
  - out_cnt: AW handshakes minus B handshakes.
  - aw_credit: AW handshakes minus W-last handshakes.
  - FSM in {RUN, DRAIN, DRAINED}.
- Reset (areset=1 at an edge): out_cnt=0, aw_credit=0, FSM=RUN, err_underflow=0, drain_done=0. Applies identically mid-burst; in-flight transactions are forgotten.
- aw_allow = (FSM==RUN) && (out_cnt < MAX_OUTSTANDING), computed from registered state only.
  - m_awvalid = s_awvalid & aw_allow.
  - s_awready = m_awready & aw_allow.
  - Zero-latency combinational pass-through; no payload registering.
- w_allow = (aw_credit != 0), registered state only.
  - m_wvalid = s_wvalid & w_allow.
  - s_wready = m_wready & w_allow.
  - An AW accepted in cycle N enables W no earlier than cycle N+1; there is no same-cycle bypass.
- aw_hs = m_awvalid & m_awready. w_last_hs = m_wvalid & m_wready & s_wlast. b_hs = bvalid & bready.
- out_cnt update:
  - +1 on aw_hs, -1 on b_hs; simultaneous aw_hs and b_hs leaves it unchanged.
  - b_hs with out_cnt==0 (and no aw_hs): out_cnt stays 0 and err_underflow is set; cleared only by reset.
- aw_credit update: +1 on aw_hs, -1 on w_last_hs; simultaneous events leave it unchanged. It never exceeds MAX_OUTSTANDING and never underflows, because W is gated.
- Non-last W beats do not change counters.
- wr_outstanding = out_cnt (registered).
- FSM transitions:
  - RUN -> DRAIN when drain_req=1.
  - DRAIN -> DRAINED when out_cnt==0 && aw_credit==0, evaluated on the post-update values of that edge.
  - DRAIN -> RUN if drain_req drops before empty.
  - DRAINED -> RUN when drain_req=0.
- AW is blocked in DRAIN and DRAINED. W and B continue so pending bursts complete.
- drain_done = (FSM==DRAINED), registered. drain_req asserted while already empty gives drain_done two edges later (RUN->DRAIN, then DRAIN->DRAINED).

Optional Feature:
- Macro: AXI4_WR_LIMIT_STATS_EN.
- When defined, adds output aw_stall_cycles [31:0], reset 0, saturating at 32'hFFFF_FFFF.
  - Increments each cycle s_awvalid=1 && aw_allow=0.
  - Counts both limit stalls and drain stalls.
- When undefined, the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then 8 back-to-back AW with m_awready=1 and no B -> wr_outstanding reaches 8. The 9th AW sees s_awready=0 and m_awvalid=0. One B handshake -> the 9th AW is accepted the next cycle.
- s_wvalid=1 with no AW issued -> m_wvalid=0 indefinitely. AW accepted at cycle N -> m_wvalid=1 at N+1. A 4-beat burst with wlast on beat 4 -> aw_credit returns to 0 and W is gated again.
- AW handshake and B handshake in the same cycle with out_cnt=3 -> wr_outstanding stays 3.
- B handshake with out_cnt=0 -> err_underflow=1 and wr_outstanding=0. err_underflow stays 1 until areset, then reads 0.
- With 2 outstanding, assert drain_req -> new AW blocked and drain_done=0. Complete 2 WLAST and 2 B -> drain_done=1 the edge after the last B. Drop drain_req -> drain_done=0 and AW flows again.
- areset mid-burst (out_cnt=5, aw_credit=2) -> all counters 0, FSM=RUN, s_wready=0 the next cycle. With AXI4_WR_LIMIT_STATS_EN, 10 stalled cycles -> aw_stall_cycles=10.
